bcd_split_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD digit splitter using iterative shift-add-3 (double-dabble).
- Successor to the combinational digit splitter: generic input width and digit count, start/done handshake, overflow detection.
- Sits between the clock/calendar counters and the 7-segment display multiplexer.
- Converts one value per request in IN_WIDTH shift cycles, so area stays small on the Basys2 part.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_add3_digit.sv | 13 +
 rtl/bcd_split_seq.sv | 94 +++++++++
 tb/tb_bcd_split_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD digit splitter and display path.
// Holds the FSM state encoding and the per-digit add-3 constants.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int                     BCD_DIGIT_W   = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH   = 4'd5;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: adds 3 when the digit is 5 or more.
// Latency: combinational. Backpressure: none (pure function).
// Reuse: shared with the display path.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);

    assign q = (d >= ADD3_THRESH) ? d + 4'd3 : d;

endmodule

// File: rtl/bcd_split_seq.sv
// Iterative binary-to-BCD splitter (shift-add-3). Build option: BCD_SPLIT_SATURATE_EN.
// Latency: done high IN_WIDTH cycles after the accepting edge; one result per IN_WIDTH+1 cycles.
// Backpressure: start is ignored while busy; it is accepted only in IDLE or DONE, with no queueing.
module bcd_split_seq
    import bcd_pkg::*;
#(
    parameter int IN_WIDTH = 16,
    parameter int DIGITS   = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [IN_WIDTH-1:0]         in,
    output logic                        busy,
    output logic                        done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                        overflow
);

    localparam int SW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);

    state_t              state;
    logic [IN_WIDTH-1:0] shreg;
    logic [SW-1:0]       scratch;
    logic [SW-1:0]       adj;
    logic [SW-1:0]       scratch_nxt;
    logic [SW-1:0]       result;
    logic [CW-1:0]       cnt;
    logic                ovf_sticky;
    logic                ovf_nxt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .d (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The bit leaving the top adjusted digit is worth 10^DIGITS: that is the overflow.
    assign scratch_nxt = {adj[SW-2:0], shreg[IN_WIDTH-1]};
    assign ovf_nxt     = ovf_sticky | adj[SW-1];

`ifdef BCD_SPLIT_SATURATE_EN
    assign result = ovf_nxt ? {DIGITS{BCD_MAX_DIGIT}} : scratch_nxt;
`else
    assign result = scratch_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd        <= '0;
            overflow   <= 1'b0;
            cnt        <= '0;
            shreg      <= '0;
            scratch    <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        shreg      <= in;
                        scratch    <= '0;
                        ovf_sticky <= 1'b0;
                        cnt        <= CW'(IN_WIDTH);
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    scratch    <= scratch_nxt;
                    shreg      <= shreg << 1;
                    ovf_sticky <= ovf_nxt;
                    cnt        <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        bcd      <= result;
                        overflow <= ovf_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_split_seq.sv
// Bench for bcd_split_seq: three parameterisations checked against a decimal reference model.
module tb_bcd_split_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start [3];
    logic [15:0] din   [3];
    logic        busy  [3];
    logic        done  [3];
    logic        ovf   [3];
    logic [19:0] bcd0;
    logic [15:0] bcd1;
    logic [11:0] bcd2;

    int n_vec = 0;
    int n_err = 0;
    int iw [3] = '{16, 16, 8};
    int dg [3] = '{5, 4, 3};

    always #5 clk = ~clk;

    bcd_split_seq #(.IN_WIDTH(16), .DIGITS(5)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .in(din[0]),
        .busy(busy[0]), .done(done[0]), .bcd(bcd0), .overflow(ovf[0])
    );
    bcd_split_seq #(.IN_WIDTH(16), .DIGITS(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .in(din[1]),
        .busy(busy[1]), .done(done[1]), .bcd(bcd1), .overflow(ovf[1])
    );
    bcd_split_seq #(.IN_WIDTH(8), .DIGITS(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .in(din[2][7:0]),
        .busy(busy[2]), .done(done[2]), .bcd(bcd2), .overflow(ovf[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] ref_bcd(input longint v, input int d);
        longint      m = 1;
        logic [19:0] r = '0;
        for (int i = 0; i < d; i++) m = m * 10;
        if (v >= m) begin
`ifdef BCD_SPLIT_SATURATE_EN
            for (int i = 0; i < d; i++) r[4*i +: 4] = 4'd9;
            return r;
`else
            v = v % m;
`endif
        end
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint v, input int d);
        longint m = 1;
        for (int i = 0; i < d; i++) m = m * 10;
        return v >= m;
    endfunction

    function automatic logic [19:0] out_bcd(input int k);
        case (k)
            0:       return bcd0;
            1:       return {4'h0, bcd1};
            default: return {8'h0, bcd2};
        endcase
    endfunction

    // One request from IDLE; checks latency, busy, result and overflow.
    task automatic convert(input int k, input logic [15:0] v);
        int cyc;
        @(negedge clk);
        start[k] = 1'b1;
        din[k]   = v;
        @(posedge clk); #1;
        start[k] = 1'b0;
        din[k]   = 16'($urandom);
        check("busy_after_start", 32'(busy[k]), 32'd1);
        cyc = 0;
        while (!done[k] && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, iw[k]);
        check("busy_at_done", 32'(busy[k]), 32'd0);
        check("bcd", 32'(out_bcd(k)), 32'(ref_bcd(longint'(v), dg[k])));
        check("overflow", 32'(ovf[k]), 32'(ref_ovf(longint'(v), dg[k])));
    endtask

    initial begin
        int          cyc;
        int          npulse;
        logic [19:0] got;
        logic [15:0] v;

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            din[k]   = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_busy", 32'(busy[k]), 32'd0);
            check("rst_done", 32'(done[k]), 32'd0);
            check("rst_bcd",  32'(out_bcd(k)), 32'd0);
            check("rst_ovf",  32'(ovf[k]), 32'd0);
        end
        rst_n = 1'b1;

        convert(0, 16'd1000);
        convert(0, 16'd2500);
        convert(0, 16'd8400);

        // Back-to-back: start held through DONE.
        @(negedge clk);
        start[0] = 1'b1;
        din[0]   = 16'd65535;
        @(posedge clk); #1;
        din[0] = 16'd0;
        cyc = 0;
        while (!done[0] && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_lat1", cyc, 16);
        check("b2b_bcd1", 32'(bcd0), 32'h65535);
        @(posedge clk); #1;
        start[0] = 1'b0;
        cyc = 1;
        while (!done[0] && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_gap", cyc, 17);
        check("b2b_bcd2", 32'(bcd0), 32'h00000);
        @(posedge clk); #1;

        // Start pulsed mid-conversion must be ignored.
        @(negedge clk);
        start[0] = 1'b1;
        din[0]   = 16'd4321;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start[0] = 1'b1;
        din[0]   = 16'd777;
        @(posedge clk); #1;
        start[0] = 1'b0;
        npulse = 0;
        got    = '0;
        for (int i = 0; i < 30; i++) begin
            if (done[0]) begin
                npulse++;
                got = bcd0;
            end
            @(posedge clk); #1;
        end
        check("ign_pulses", npulse, 1);
        check("ign_bcd", 32'(got), 32'h04321);

        // Reset during the 8th shift cycle aborts the conversion.
        @(negedge clk);
        start[0] = 1'b1;
        din[0]   = 16'd8400;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_done", 32'(done[0]), 32'd0);
        check("abort_bcd",  32'(bcd0), 32'd0);
        check("abort_ovf",  32'(ovf[0]), 32'd0);
        npulse = 0;
        for (int i = 0; i < 25; i++) begin
            if (done[0]) npulse++;
            @(posedge clk); #1;
        end
        check("abort_no_done", npulse, 0);
        convert(0, 16'd8400);
        check("fresh_8400", 32'(bcd0), 32'h08400);

        convert(1, 16'd12345);
`ifdef BCD_SPLIT_SATURATE_EN
        check("d4_sat", 32'(bcd1), 32'h9999);
`else
        check("d4_trunc", 32'(bcd1), 32'h2345);
`endif
        convert(1, 16'd9999);
        convert(1, 16'd10000);
        convert(2, 16'd255);
        check("w8_255", 32'(bcd2), 32'h255);
        convert(2, 16'd0);

        for (int i = 0; i < 20; i++) begin
            v = 16'($urandom);
            convert(0, v);
            v = 16'($urandom);
            convert(1, v);
            v = 16'($urandom_range(0, 255));
            convert(2, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
